regfile_mp: RTL

- Parametrised multi-port register file for the next pipelined datapath core; replaces the single-write/dual-read file.
- Generalised in data width, depth, read-port and write-port count.
- Adds a per-register pending scoreboard for hazard detection.
- Adds a sequential clear engine that flushes the array without asserting reset.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_clr_fsm.sv | 61 ++++++
 rtl/regfile_mp.sv | 105 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// The optional REGFILE_BYPASS_EN macro is consumed by regfile_mp.sv.
package regfile_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  typedef logic [RF_DW-1:0] word_t;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between a pipeline front end (master) and regfile_mp (slave).
// Write/read ports are packed vectors, port k at [k*W +: W].
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW     = RF_DW,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);

  localparam int AW = $clog2(DEPTH);

  logic [NWRITE-1:0]    wen;
  logic [NWRITE*AW-1:0] wsel;
  logic [NWRITE*DW-1:0] wdat;
  logic [NREAD*AW-1:0]  rsel;
  logic [NREAD*DW-1:0]  rdat;
  logic [NREAD-1:0]     rrdy;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_sel;
  logic [DEPTH-1:0]     pend;
  logic                 clr_req;
  logic                 clr_busy;

  modport master (
    output wen, wsel, wdat, rsel, alloc_en, alloc_sel, clr_req,
    input  rdat, rrdy, pend, clr_busy
  );

  modport slave (
    input  wen, wsel, wdat, rsel, alloc_en, alloc_sel, clr_req,
    output rdat, rrdy, pend, clr_busy
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks registers 1..DEPTH-1, one per cycle,
// emitting a zeroing strobe; clr_start marks the edge that enters CLEAR.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_start,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  rf_state_t     state, state_nx;
  logic [AW-1:0] idx, idx_nx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= RF_IDLE;
      idx   <= IDX_FIRST;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Requests arriving while already clearing are ignored, never restarted.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    clr_busy  = 1'b0;
    clr_start = 1'b0;
    clr_we    = 1'b0;
    clr_idx   = idx;
    case (state)
      RF_IDLE: begin
        idx_nx = IDX_FIRST;
        if (clr_req) begin
          state_nx  = RF_CLEAR;
          clr_start = 1'b1;
        end
      end
      RF_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        idx_nx   = idx + AW'(1);
        if (idx == IDX_LAST) begin
          state_nx = RF_IDLE;
        end
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard and sequential clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW     = RF_DW,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input logic          clk,
  input logic          n_rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]     regs [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [NWRITE-1:0] wr_ok;
  logic              clr_busy;
  logic              clr_start;
  logic              clr_we;
  logic [AW-1:0]     clr_idx;

  regfile_clr_fsm #(.DEPTH(DEPTH)) u_clr (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr_req   (bus.clr_req),
    .clr_busy  (clr_busy),
    .clr_start (clr_start),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NWRITE; k++) begin
      wr_ok[k] = bus.wen[k] && (bus.wsel[k*AW +: AW] != '0) && !clr_busy;
    end
  end

  // Loop order gives the higher write port priority on a select collision.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (clr_we) begin
      regs[clr_idx] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_ok[k]) begin
          regs[bus.wsel[k*AW +: AW]] <= bus.wdat[k*DW +: DW];
        end
      end
    end
  end

  // Alloc is applied after the write clears so a same-cycle alloc wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q <= '0;
    end else if (clr_start) begin
      pend_q <= '0;
    end else if (!clr_busy) begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_ok[k]) begin
          pend_q[bus.wsel[k*AW +: AW]] <= 1'b0;
        end
      end
      if (bus.alloc_en && (bus.alloc_sel != '0)) begin
        pend_q[bus.alloc_sel] <= 1'b1;
      end
    end
  end

  assign bus.pend     = pend_q;
  assign bus.clr_busy = clr_busy;

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
    logic          rdy;

    assign sel = bus.rsel[i*AW +: AW];

    always_comb begin
      data = (sel == '0) ? '0 : regs[sel];
      rdy  = ~pend_q[sel];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_ok[k] && (bus.wsel[k*AW +: AW] == sel)) begin
          data = bus.wdat[k*DW +: DW];
          rdy  = 1'b1;
        end
      end
`endif
    end

    assign bus.rdat[i*DW +: DW] = data;
    assign bus.rrdy[i]          = rdy;
  end

endmodule
